dfx_debug_reg_bank: RTL and testbench
=====================================

DFX_DEBUG_REG_BANK -- requirements
Module: dfx_debug_reg_bank

Interface
- REQ-001: Parameter ID_VALUE, default 32'hDF10_0001, constant returned by the ID register.
- REQ-002: Parameter EVT_WIDTH, default 16, number of sticky event inputs (range 1..32).
- REQ-003: McuAxiClock  in  1  sole clock; all logic rising-edge.
- REQ-004: aMcuAxiReset_n  in  1  asynchronous, active-low reset; assertion is asynchronous; deassertion is sampled on McuAxiClock.
- REQ-005: mDebugMcu_AXI_awaddr/awprot/awvalid  in  32/3/1  AXI4-Lite write address from the MCU debug master; awready  out  1.
- REQ-006: mDebugMcu_AXI_wdata/wstrb/wvalid  in  32/4/1  write data channel; wready  out  1.
- REQ-007: mDebugMcu_AXI_bresp/bvalid  out  2/1  write response channel; bready  in  1.
- REQ-008: mDebugMcu_AXI_araddr/arprot/arvalid  in  32/3/1  read address channel; arready  out  1.
- REQ-009: mDebugMcu_AXI_rdata/rresp/rvalid  out  32/2/1  read data channel; rready  in  1.
- REQ-010: mDfxControl  out  32  CONTROL register contents.
- REQ-011: mDfxStatus  in  32  live status, already synchronous to McuAxiClock.
- REQ-012: mDfxEvent  in  EVT_WIDTH  single-cycle event pulses.
- REQ-013: mDfxIrq  out  1  high when any bit of (EVENT & EVT_MASK) is set.

Function
- REQ-014: Address decode uses awaddr[5:2]/araddr[5:2] only; bits [31:6] and [1:0] are ignored.
- REQ-015: Register map: 0x00 ID (RO); 0x04 SCRATCH (RW); 0x08 CONTROL (RW); 0x0C STATUS (RO, mDfxStatus sampled at the AR handshake); 0x10 EVENT (W1C, EVT_WIDTH bits); 0x14 EVT_MASK (RW, EVT_WIDTH bits); 0x18 CYCLE_CNT (RO, free-running 32-bit counter, wraps from FFFF_FFFF to 0).
- REQ-016: Unmapped offsets 0x1C-0x3C: reads return rdata=0 with rresp=SLVERR (2'b10); writes have no effect and return bresp=SLVERR.
- REQ-017: Writes to RO registers are ignored and return bresp=OKAY.
- REQ-018: AW and W are accepted independently. awready is high while no address is held; wready is high while no data is held. Each channel holds its beat until the write executes.
- REQ-019: The write executes in the first cycle in which both address and data are held and bvalid=0. The register updates at the end of that cycle, and bvalid asserts in the next cycle.
- REQ-020: At most one write is outstanding. awready and wready stay low while bvalid=1 and the respective channel is still held.
- REQ-021: bvalid holds, with bresp stable, until bready=1. The held AW/W slots are freed in the cycle of the B handshake.
- REQ-022: wstrb[i] enables byte i for RW registers. For EVENT, a set bit in a strobed byte clears the corresponding event bit.
- REQ-023: Read: arready=1 when rvalid=0. On the AR handshake, rdata/rresp register and rvalid asserts next cycle (latency 1). rvalid holds until rready; rdata is stable while rvalid=1.
- REQ-024: An EVENT bit sets on the cycle after its mDfxEvent bit is high. If a set and a W1C clear of the same bit occur in the same cycle, the set wins.
- REQ-025: Bits of EVENT/EVT_MASK above EVT_WIDTH-1 read as 0 and are not writable.
- REQ-026: mDfxIrq is registered and follows EVENT/EVT_MASK with 1 cycle of latency.
- REQ-027: Read and write paths are independent. A read of a register in the same cycle as a write to it returns the pre-write value.

Reset
- REQ-028: On reset: all ready/valid outputs = 0; bresp = 0; rresp = 0; rdata = 0; SCRATCH = 0; CONTROL = 0; EVENT = 0; EVT_MASK = 0; CYCLE_CNT = 0; mDfxIrq = 0; held AW/W slots are empty.
- REQ-029: Reset asserted mid-transaction discards pending beats with no response. awready, wready and arready assert in the first cycle after deassertion.

Verification
- REQ-030: Read 0x00 after reset -> rdata=ID_VALUE, rresp=OKAY, rvalid exactly 1 cycle after the AR handshake.
- REQ-031: W beat presented 3 cycles before AW (0x08, data A5A5_5A5A, wstrb=4'b0101) -> mDfxControl=0x00A5_005A; a single bvalid with OKAY.
- REQ-032: Write to 0x20 and read from 0x3C -> bresp=SLVERR; rresp=SLVERR with rdata=0; all registers unchanged.
- REQ-033: Pulse mDfxEvent[3] with EVT_MASK=0x8 -> EVENT=0x8 and mDfxIrq=1. W1C 0x8 in the same cycle as a new pulse on bit 3 -> bit remains 1. Separate W1C -> bit cleared and mDfxIrq=0 one cycle later.
- REQ-034: Hold bready=0 for 5 cycles after a write -> bvalid stays high with bresp stable; a second AW is not accepted until the B handshake.
- REQ-035: Assert aMcuAxiReset_n=0 while rvalid=1 with rready=0 -> rvalid=0 immediately; CONTROL=0; arready=1 on the first cycle after deassertion.

Source files
------------

// File: rtl/dfx_debug_reg_bank_if.sv
// AXI4-Lite channel bundle between the MCU debug master and the DFX register bank.
interface dfx_debug_reg_bank_if;
  logic [31:0] awaddr;
  logic [2:0]  awprot;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic [31:0] araddr;
  logic [2:0]  arprot;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;

  modport master (
    output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
    output araddr, arprot, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
    input  araddr, arprot, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/dfx_debug_reg_bank.sv
// DFX debug register bank: ID, scratch, control, live status, sticky W1C
// events with mask and interrupt, and a free-running cycle counter, all
// reached from the MCU debug master over AXI4-Lite.
module dfx_debug_reg_bank #(
  parameter logic [31:0] ID_VALUE  = 32'hDF10_0001,
  parameter int unsigned EVT_WIDTH = 16
) (
  input  logic                  McuAxiClock,
  input  logic                  aMcuAxiReset_n,
  dfx_debug_reg_bank_if.slave   mDebugMcu_AXI,
  output logic [31:0]           mDfxControl,
  input  logic [31:0]           mDfxStatus,
  input  logic [EVT_WIDTH-1:0]  mDfxEvent,
  output logic                  mDfxIrq
);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [3:0] {
    REG_ID        = 4'h0,
    REG_SCRATCH   = 4'h1,
    REG_CONTROL   = 4'h2,
    REG_STATUS    = 4'h3,
    REG_EVENT     = 4'h4,
    REG_EVT_MASK  = 4'h5,
    REG_CYCLE_CNT = 4'h6
  } regSel_t;

  logic                 live;
  logic                 awHeld, wHeld;
  logic [3:0]           awIdx;
  logic [31:0]          wDataQ;
  logic [3:0]           wStrbQ;
  logic                 bValidQ;
  logic [1:0]           bRespQ;
  logic                 rValidQ;
  logic [1:0]           rRespQ;
  logic [31:0]          rDataQ;
  logic [31:0]          scratch, control, cycleCnt;
  logic [EVT_WIDTH-1:0] eventQ, evtMask;
  logic                 irqQ;

  logic                 awHs, wHs, arHs, bHs, doWrite, writeMapped;
  logic [3:0]           arIdx;
  logic [31:0]          wMask, wBits, readMux;
  logic [1:0]           readResp;
  logic [EVT_WIDTH-1:0] evtClr;
  logic                 unusedAxiBits;

  assign unusedAxiBits = ^{mDebugMcu_AXI.awaddr[31:6], mDebugMcu_AXI.awaddr[1:0],
                           mDebugMcu_AXI.araddr[31:6], mDebugMcu_AXI.araddr[1:0],
                           mDebugMcu_AXI.awprot, mDebugMcu_AXI.arprot};

  // Readies are held low during reset and come up on the first clock after release.
  assign mDebugMcu_AXI.awready = live && !awHeld;
  assign mDebugMcu_AXI.wready  = live && !wHeld;
  assign mDebugMcu_AXI.arready = live && !rValidQ;
  assign mDebugMcu_AXI.bvalid  = bValidQ;
  assign mDebugMcu_AXI.bresp   = bRespQ;
  assign mDebugMcu_AXI.rvalid  = rValidQ;
  assign mDebugMcu_AXI.rresp   = rRespQ;
  assign mDebugMcu_AXI.rdata   = rDataQ;
  assign mDfxControl           = control;
  assign mDfxIrq               = irqQ;

  assign awHs        = mDebugMcu_AXI.awvalid && mDebugMcu_AXI.awready;
  assign wHs         = mDebugMcu_AXI.wvalid && mDebugMcu_AXI.wready;
  assign arHs        = mDebugMcu_AXI.arvalid && mDebugMcu_AXI.arready;
  assign bHs         = bValidQ && mDebugMcu_AXI.bready;
  assign doWrite     = awHeld && wHeld && !bValidQ;
  assign writeMapped = (awIdx <= REG_CYCLE_CNT);
  assign arIdx       = mDebugMcu_AXI.araddr[5:2];
  assign wBits       = wDataQ & wMask;
  assign evtClr      = (doWrite && awIdx == REG_EVENT) ? EVT_WIDTH'(wBits) : '0;

  // Expand the held byte strobes into a bit mask.
  always_comb begin
    wMask = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      if (wStrbQ[i]) wMask[8*i +: 8] = 8'hFF;
    end
  end

  // Read data/response selection from the current (pre-write) register values.
  always_comb begin
    readMux  = '0;
    readResp = RESP_OKAY;
    case (arIdx)
      REG_ID:        readMux = ID_VALUE;
      REG_SCRATCH:   readMux = scratch;
      REG_CONTROL:   readMux = control;
      REG_STATUS:    readMux = mDfxStatus;
      REG_EVENT:     readMux = 32'(eventQ);
      REG_EVT_MASK:  readMux = 32'(evtMask);
      REG_CYCLE_CNT: readMux = cycleCnt;
      default:       readResp = RESP_SLVERR;
    endcase
  end

  // Write channel slots and single-outstanding B response.
  always_ff @(posedge McuAxiClock or negedge aMcuAxiReset_n) begin
    if (!aMcuAxiReset_n) begin
      live    <= 1'b0;
      awHeld  <= 1'b0;
      wHeld   <= 1'b0;
      awIdx   <= '0;
      wDataQ  <= '0;
      wStrbQ  <= '0;
      bValidQ <= 1'b0;
      bRespQ  <= RESP_OKAY;
    end else begin
      live <= 1'b1;
      if (awHs) begin
        awHeld <= 1'b1;
        awIdx  <= mDebugMcu_AXI.awaddr[5:2];
      end
      if (wHs) begin
        wHeld  <= 1'b1;
        wDataQ <= mDebugMcu_AXI.wdata;
        wStrbQ <= mDebugMcu_AXI.wstrb;
      end
      if (doWrite) begin
        bValidQ <= 1'b1;
        bRespQ  <= writeMapped ? RESP_OKAY : RESP_SLVERR;
      end else if (bHs) begin
        bValidQ <= 1'b0;
        awHeld  <= 1'b0;
        wHeld   <= 1'b0;
      end
    end
  end

  // Writable registers; a new event pulse overrides a same-cycle W1C clear.
  always_ff @(posedge McuAxiClock or negedge aMcuAxiReset_n) begin
    if (!aMcuAxiReset_n) begin
      scratch <= '0;
      control <= '0;
      evtMask <= '0;
      eventQ  <= '0;
    end else begin
      if (doWrite && awIdx == REG_SCRATCH) scratch <= (scratch & ~wMask) | wBits;
      if (doWrite && awIdx == REG_CONTROL) control <= (control & ~wMask) | wBits;
      if (doWrite && awIdx == REG_EVT_MASK)
        evtMask <= EVT_WIDTH'((32'(evtMask) & ~wMask) | wBits);
      eventQ <= (eventQ & ~evtClr) | mDfxEvent;
    end
  end

  // Read channel: one-cycle latency, data held until rready.
  always_ff @(posedge McuAxiClock or negedge aMcuAxiReset_n) begin
    if (!aMcuAxiReset_n) begin
      rValidQ <= 1'b0;
      rRespQ  <= RESP_OKAY;
      rDataQ  <= '0;
    end else if (arHs) begin
      rValidQ <= 1'b1;
      rRespQ  <= readResp;
      rDataQ  <= readMux;
    end else if (rValidQ && mDebugMcu_AXI.rready) begin
      rValidQ <= 1'b0;
    end
  end

  // Free-running cycle counter and registered interrupt.
  always_ff @(posedge McuAxiClock or negedge aMcuAxiReset_n) begin
    if (!aMcuAxiReset_n) begin
      cycleCnt <= '0;
      irqQ     <= 1'b0;
    end else begin
      cycleCnt <= cycleCnt + 32'd1;
      irqQ     <= |(eventQ & evtMask);
    end
  end

endmodule

// File: tb/tb_dfx_debug_reg_bank.sv
// Randomised scoreboard bench for dfx_debug_reg_bank.
`timescale 1ns/1ps
module tb_dfx_debug_reg_bank;
  localparam logic [31:0] ID      = 32'hDF10_0001;
  localparam int          EVT     = 16;
  localparam logic [31:0] EVT_ALL = 32'h0000_FFFF;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [31:0] status = '0;
  logic [EVT-1:0] evIn = '0;
  logic [31:0] control;
  logic irq;

  dfx_debug_reg_bank_if bus();

  dfx_debug_reg_bank #(.ID_VALUE(ID), .EVT_WIDTH(EVT)) dut (
    .McuAxiClock(clk), .aMcuAxiReset_n(rst_n), .mDebugMcu_AXI(bus),
    .mDfxControl(control), .mDfxStatus(status), .mDfxEvent(evIn), .mDfxIrq(irq)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] data; logic [1:0] resp; } exp_t;
  exp_t rq[$];
  logic [1:0] bq[$];

  int tests = 0;
  int fails = 0;
  logic [31:0] mScratch = '0, mControl = '0, mEvent = '0, mMask = '0;
  logic [31:0] tbCyc;

  // Reference cycle count: cycles elapsed since reset release.
  always @(posedge clk or negedge rst_n)
    if (!rst_n) tbCyc <= '0; else tbCyc <= tbCyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: pop expectations whenever a B or R handshake is presented.
  always @(negedge clk) begin
    exp_t e;
    logic [1:0] b;
    if (rst_n && bus.bvalid && bus.bready) begin
      if (bq.size() == 0) begin
        tests++; fails++;
        $display("FAIL b-unexpected: got bresp %b expected no response", bus.bresp);
      end else begin
        b = bq.pop_front();
        check("bresp", 32'(bus.bresp), 32'(b));
      end
    end
    if (rst_n && bus.rvalid && bus.rready) begin
      if (rq.size() == 0) begin
        tests++; fails++;
        $display("FAIL r-unexpected: got rdata %h expected no response", bus.rdata);
      end else begin
        e = rq.pop_front();
        check("rdata", bus.rdata, e.data);
        check("rresp", 32'(bus.rresp), 32'(e.resp));
      end
    end
  end

  function automatic logic [31:0] byteMask(input logic [3:0] s);
    logic [31:0] m = '0;
    for (int i = 0; i < 4; i++) if (s[i]) m[8*i +: 8] = 8'hFF;
    return m;
  endfunction

  task automatic modelWrite(input logic [31:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, output logic [1:0] resp);
    logic [31:0] m = byteMask(strb);
    resp = 2'b00;
    case (int'(addr[5:2]))
      1: mScratch = (mScratch & ~m) | (data & m);
      2: mControl = (mControl & ~m) | (data & m);
      4: mEvent = mEvent & ~(data & m);
      5: mMask = ((mMask & ~m) | (data & m)) & EVT_ALL;
      0, 3, 6: ;
      default: resp = 2'b10;
    endcase
  endtask

  function automatic exp_t modelRead(input logic [31:0] addr, input logic [31:0] st);
    exp_t e;
    e.resp = 2'b00;
    case (int'(addr[5:2]))
      0: e.data = ID;
      1: e.data = mScratch;
      2: e.data = mControl;
      3: e.data = st;
      4: e.data = mEvent;
      5: e.data = mMask;
      6: e.data = tbCyc;
      default: begin e.data = '0; e.resp = 2'b10; end
    endcase
    return e;
  endfunction

  // Drive AW and W with independent delays; returns in the cycle the write executes.
  task automatic writeIssue(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                            input int awDly, input int wDly, input logic [EVT-1:0] pulse);
    bit awDone = 0, wDone = 0, awNow, wNow;
    int c = 0;
    logic [1:0] r;
    @(posedge clk); #1;
    while (!(awDone && wDone) && c < 50) begin
      bus.awaddr = addr; bus.awprot = 3'($urandom); bus.wdata = data; bus.wstrb = strb;
      bus.awvalid = !awDone && c >= awDly;
      bus.wvalid  = !wDone && c >= wDly;
      awNow = bus.awvalid && bus.awready;
      wNow  = bus.wvalid && bus.wready;
      @(posedge clk); #1;
      if (awNow) awDone = 1;
      if (wNow) wDone = 1;
      c++;
    end
    bus.awvalid = 0; bus.wvalid = 0;
    if (!(awDone && wDone)) begin
      tests++; fails++;
      $display("FAIL write-accept: got aw=%0d w=%0d expected both accepted", awDone, wDone);
    end
    evIn = pulse;
    modelWrite(addr, data, strb, r);
    mEvent = mEvent | 32'(pulse);
    bq.push_back(r);
  endtask

  task automatic writeResp(input int hold, input bit pokeAw);
    int c = 0;
    while (!bus.bvalid && c < 20) begin @(posedge clk); #1; c++; end
    for (int h = 0; h < hold; h++) begin
      if (pokeAw) begin bus.awaddr = 32'h4; bus.awvalid = 1; end
      check("bvalid-hold", 32'(bus.bvalid), 1);
      check("awready-while-b", 32'(bus.awready), 0);
      if (bq.size() > 0) check("bresp-hold", 32'(bus.bresp), 32'(bq[0]));
      @(posedge clk); #1;
    end
    bus.bready = 1;
    check("bvalid-at-b", 32'(bus.bvalid), 1);
    @(posedge clk); #1;
    bus.bready = 0; bus.awvalid = 0;
    check("awready-after-b", 32'(bus.awready), 1);
    check("wready-after-b", 32'(bus.wready), 1);
    check("control-out", control, mControl);
    check("irq", 32'(irq), 32'(|(mEvent & mMask)));
  endtask

  task automatic doWrite(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                         input int awDly, input int wDly, input int hold, input logic [EVT-1:0] pulse);
    writeIssue(addr, data, strb, awDly, wDly, pulse);
    @(posedge clk); #1;
    evIn = '0;
    check("bvalid-latency", 32'(bus.bvalid), 1);
    writeResp(hold, 1'b0);
  endtask

  task automatic readOp(input logic [31:0] addr, input int hold, input bit ovr, input logic [31:0] ovrData);
    exp_t e;
    bit hs = 0;
    int c = 0;
    @(posedge clk); #1;
    status = $urandom; bus.araddr = addr; bus.arprot = 3'($urandom); bus.arvalid = 1;
    while (c < 50) begin
      if (bus.arready) begin
        hs = 1;
        e = modelRead(addr, status);
        if (ovr) e.data = ovrData;
        rq.push_back(e);
      end
      @(posedge clk); #1;
      c++;
      if (hs) break;
    end
    bus.arvalid = 0;
    status = $urandom;
    if (!hs) begin
      tests++; fails++;
      $display("FAIL read-accept: got no arready expected handshake");
    end
    check("rvalid-latency", 32'(bus.rvalid), 1);
    for (int h = 0; h < hold; h++) begin
      check("rvalid-hold", 32'(bus.rvalid), 1);
      @(posedge clk); #1;
    end
    bus.rready = 1;
    @(posedge clk); #1;
    bus.rready = 0;
  endtask

  task automatic modelReset();
    mScratch = '0; mControl = '0; mEvent = '0; mMask = '0;
  endtask

  initial begin
    #1000000;
    fails++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    logic [31:0] a, old;
    bus.awaddr = '0; bus.awprot = '0; bus.awvalid = 0; bus.wdata = '0; bus.wstrb = '0;
    bus.wvalid = 0; bus.bready = 0; bus.araddr = '0; bus.arprot = '0; bus.arvalid = 0;
    bus.rready = 0;
    #23;
    check("rst-awready", 32'(bus.awready), 0);
    check("rst-wready", 32'(bus.wready), 0);
    check("rst-arready", 32'(bus.arready), 0);
    check("rst-bvalid", 32'(bus.bvalid), 0);
    check("rst-rvalid", 32'(bus.rvalid), 0);
    check("rst-resp", 32'({bus.bresp, bus.rresp}), 0);
    check("rst-rdata", bus.rdata, 0);
    check("rst-control", control, 0);
    check("rst-irq", 32'(irq), 0);
    @(posedge clk); #1 rst_n = 1;
    @(posedge clk); #1;
    check("post-rst-readies", 32'({bus.awready, bus.wready, bus.arready}), 32'h7);

    readOp(32'h0, 0, 0, '0);
    foreach (a[i]) ;
    for (int i = 1; i < 7; i++) readOp(32'(i * 4), 1, 0, '0);

    doWrite(32'h8, 32'hA5A5_5A5A, 4'b0101, 3, 0, 0, '0);
    check("control-strobe", control, 32'h00A5_005A);

    doWrite(32'h20, 32'hFFFF_FFFF, 4'hF, 0, 0, 1, '0);
    readOp(32'h3C, 0, 0, '0);
    readOp(32'h4, 0, 0, '0);
    readOp(32'h8, 0, 0, '0);

    writeIssue(32'h4, 32'h1234_5678, 4'hF, 0, 0, '0);
    writeResp(5, 1'b1);
    readOp(32'h4, 0, 0, '0);

    doWrite(32'h14, 32'h0000_0008, 4'hF, 0, 0, 0, '0);
    @(posedge clk); #1 evIn = 16'h0008;
    @(posedge clk); #1 evIn = '0; mEvent = mEvent | 32'h8;
    @(posedge clk); #1;
    check("irq-on-event", 32'(irq), 1);
    readOp(32'h10, 0, 0, '0);
    doWrite(32'h10, 32'h0000_0008, 4'hF, 0, 0, 0, 16'h0008);
    readOp(32'h10, 0, 0, '0);
    writeIssue(32'h10, 32'h0000_0008, 4'hF, 1, 0, '0);
    check("irq-before-clear", 32'(irq), 1);
    @(posedge clk); #1;
    check("irq-clear-edge", 32'(irq), 1);
    @(posedge clk); #1;
    check("irq-cleared", 32'(irq), 0);
    writeResp(0, 1'b0);
    readOp(32'h10, 0, 0, '0);

    old = mScratch;
    fork
      begin
        writeIssue(32'h4, 32'hCAFE_F00D, 4'hF, 0, 0, '0);
        @(posedge clk); #1;
        writeResp(0, 1'b0);
      end
      begin
        @(posedge clk); #1;
        readOp(32'h4, 0, 1, old);
      end
    join
    readOp(32'h4, 0, 0, '0);

    for (int n = 0; n < 60; n++) begin
      int idx = $urandom_range(0, 9);
      if (idx > 6) idx = $urandom_range(7, 15);
      a = $urandom;
      a[5:2] = 4'(idx);
      if ($urandom_range(0, 1) == 1)
        doWrite(a, $urandom, 4'($urandom), $urandom_range(0, 3), $urandom_range(0, 3),
                $urandom_range(0, 3), '0);
      else
        readOp(a, $urandom_range(0, 3), 0, '0);
    end

    doWrite(32'h8, 32'hFFFF_FFFF, 4'hF, 0, 0, 0, '0);
    @(posedge clk); #1 bus.araddr = 32'h0; bus.arvalid = 1;
    @(posedge clk); #1 bus.arvalid = 0;
    check("rvalid-before-reset", 32'(bus.rvalid), 1);
    rst_n = 0;
    #1;
    check("reset-rvalid", 32'(bus.rvalid), 0);
    check("reset-control", control, 0);
    check("reset-arready", 32'(bus.arready), 0);
    modelReset();
    @(posedge clk); #1 rst_n = 1;
    @(posedge clk); #1;
    check("release-readies", 32'({bus.awready, bus.wready, bus.arready}), 32'h7);
    readOp(32'h8, 0, 0, '0);
    readOp(32'h14, 0, 0, '0);

    repeat (3) @(posedge clk);
    check("r-queue-drained", 32'(rq.size()), 0);
    check("b-queue-drained", 32'(bq.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
